fp_div_sequencer: RTL and testbench

Multi-cycle issue/writeback controller wrapped around the combinational single-precision FP divider.
- Latches operands and destination register on a start request.
- Holds the operands stable on the divider inputs for a fixed number of cycles, modelling the divider as a multicycle path.
- Captures the quotient and exception flags, then issues one write-back pulse to the FP register file.
- Maintains sticky divide-by-zero, overflow and underflow status bits for the FP control/status register.

---
 rtl/fp_div_sequencer_if.sv | 24 ++
 rtl/fp_div_sequencer.sv | 157 +++++++++++++++
 tb/tb_fp_div_sequencer.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_div_sequencer_if.sv
// Issue and write-back handshake between the FP pipeline and fp_div_sequencer.
interface fp_div_sequencer_if #(
    parameter int unsigned REG_ADDR_W = 5
);
    logic                  start;
    logic [31:0]           op_a;
    logic [31:0]           op_b;
    logic [REG_ADDR_W-1:0] dest_reg;
    logic                  flush;
    logic                  busy;
    logic                  wb_en;
    logic [REG_ADDR_W-1:0] wb_reg;
    logic [31:0]           wb_data;

    modport master (
        output start, op_a, op_b, dest_reg, flush,
        input  busy, wb_en, wb_reg, wb_data
    );

    modport slave (
        input  start, op_a, op_b, dest_reg, flush,
        output busy, wb_en, wb_reg, wb_data
    );
endinterface

// File: rtl/fp_div_sequencer.sv
// Issue/write-back sequencer around a combinational FP divider treated as a LATENCY-cycle multicycle path.
// Define FP_DIV_SEQ_PERF_EN to add the div_count/flush_count performance counters and perf_clear.
module fp_div_sequencer #(
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    fp_div_sequencer_if.slave issue,
    output logic [31:0]       div_a,
    output logic [31:0]       div_b,
    input  logic [31:0]       div_result,
    input  logic              div_dz,
    input  logic              div_ov,
    input  logic              div_uf,
    output logic              sticky_dz,
    output logic              sticky_ov,
    output logic              sticky_uf,
    input  logic              flag_clear
`ifdef FP_DIV_SEQ_PERF_EN
    ,
    input  logic              perf_clear,
    output logic [31:0]       div_count,
    output logic [31:0]       flush_count
`endif
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned FLAG_W = 3;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, WB} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     div_a_q, div_a_d;
    logic [DATA_W-1:0]     div_b_q, div_b_d;
    logic [DATA_W-1:0]     wb_data_q, wb_data_d;
    logic [REG_ADDR_W-1:0] wb_reg_q, wb_reg_d;
    logic                  busy_q, busy_d;
    logic                  wb_en_q, wb_en_d;
    logic [FLAG_W-1:0]     pend_q, pend_d;
    logic [FLAG_W-1:0]     sticky_q, sticky_d;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_a_q   <= '0;
            div_b_q   <= '0;
            wb_data_q <= '0;
            wb_reg_q  <= '0;
            busy_q    <= 1'b0;
            wb_en_q   <= 1'b0;
            pend_q    <= '0;
            sticky_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_a_q   <= div_a_d;
            div_b_q   <= div_b_d;
            wb_data_q <= wb_data_d;
            wb_reg_q  <= wb_reg_d;
            busy_q    <= busy_d;
            wb_en_q   <= wb_en_d;
            pend_q    <= pend_d;
            sticky_q  <= sticky_d;
        end
    end

    // Next-state and next-output logic; the WB-cycle OR overrides a coincident clear.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_a_d   = div_a_q;
        div_b_d   = div_b_q;
        wb_data_d = wb_data_q;
        wb_reg_d  = wb_reg_q;
        busy_d    = busy_q;
        wb_en_d   = 1'b0;
        pend_d    = pend_q;
        sticky_d  = flag_clear ? '0 : sticky_q;

        unique case (state_q)
            IDLE: begin
                if (issue.start && !issue.flush) begin
                    div_a_d  = issue.op_a;
                    div_b_d  = issue.op_b;
                    wb_reg_d = issue.dest_reg;
                    cnt_d    = CNT_LOAD;
                    busy_d   = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (issue.flush) begin
                    cnt_d   = '0;
                    pend_d  = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    wb_data_d = div_result;
                    pend_d    = {div_dz, div_ov, div_uf};
                    wb_en_d   = 1'b1;
                    state_d   = WB;
                end
            end
            WB: begin
                sticky_d = sticky_d | pend_q;
                pend_d   = '0;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign div_a         = div_a_q;
    assign div_b         = div_b_q;
    assign issue.busy    = busy_q;
    assign issue.wb_en   = wb_en_q;
    assign issue.wb_reg  = wb_reg_q;
    assign issue.wb_data = wb_data_q;
    assign sticky_dz     = sticky_q[2];
    assign sticky_ov     = sticky_q[1];
    assign sticky_uf     = sticky_q[0];

`ifdef FP_DIV_SEQ_PERF_EN
    logic [31:0] div_count_q, flush_count_q;

    // Completion and squash counters; perf_clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_count_q   <= '0;
            flush_count_q <= '0;
        end else if (perf_clear) begin
            div_count_q   <= '0;
            flush_count_q <= '0;
        end else begin
            if (state_q == WB) begin
                div_count_q <= div_count_q + 32'd1;
            end
            if ((state_q == WAIT) && issue.flush) begin
                flush_count_q <= flush_count_q + 32'd1;
            end
        end
    end

    assign div_count   = div_count_q;
    assign flush_count = flush_count_q;
`endif
endmodule

// File: tb/tb_fp_div_sequencer.sv
// Self-checking bench for fp_div_sequencer: a stand-in divider plus a transaction-level model of timing and sticky flags.
`timescale 1ns/1ps
module tb_fp_div_sequencer;
    localparam int unsigned LATENCY    = 4;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int          NCYC       = 3 * (LATENCY + 2);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] div_a, div_b, div_result;
    logic        div_dz, div_ov, div_uf;
    logic        sticky_dz, sticky_ov, sticky_uf;
    logic        flag_clear;
`ifdef FP_DIV_SEQ_PERF_EN
    logic        perf_clear;
    logic [31:0] div_count, flush_count;
`endif

    int          checks = 0;
    int          failures = 0;
    logic [2:0]  exp_sticky = 3'b000;

    always #5 clk = ~clk;

    fp_div_sequencer_if #(.REG_ADDR_W(REG_ADDR_W)) bus ();

    fp_div_sequencer #(.LATENCY(LATENCY), .REG_ADDR_W(REG_ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue      (bus.slave),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_result (div_result),
        .div_dz     (div_dz),
        .div_ov     (div_ov),
        .div_uf     (div_uf),
        .sticky_dz  (sticky_dz),
        .sticky_ov  (sticky_ov),
        .sticky_uf  (sticky_uf),
        .flag_clear (flag_clear)
`ifdef FP_DIV_SEQ_PERF_EN
        ,
        .perf_clear (perf_clear),
        .div_count  (div_count),
        .flush_count(flush_count)
`endif
    );

    // Stand-in divider: exact for the test-plan operands, a cheap scramble otherwise; returns {q, dz, ov, uf}.
    function automatic logic [34:0] div_model(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic        dz, ov, uf;
        if (a == 32'h40C0_0000 && b == 32'h4000_0000) begin
            q = 32'h4040_0000; dz = 1'b0; ov = 1'b0; uf = 1'b0;
        end else if (b[30:0] == 31'd0) begin
            q = {a[31] ^ b[31], 8'hFF, 23'd0}; dz = 1'b1; ov = 1'b0; uf = 1'b0;
        end else begin
            q = a ^ {b[15:0], b[31:16]}; dz = 1'b0; ov = a[3] & b[3]; uf = a[4] & b[4];
        end
        return {q, dz, ov, uf};
    endfunction

    assign {div_result, div_dz, div_ov, div_uf} = div_model(div_a, div_b);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and let it run to completion without checking anything.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [REG_ADDR_W-1:0] d);
        logic [34:0] r;
        r = div_model(a, b);
        bus.op_a = a; bus.op_b = b; bus.dest_reg = d; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (LATENCY + 1) tick();
        exp_sticky = exp_sticky | r[2:0];
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.dest_reg = '0; bus.flush = 1'b0;
        flag_clear = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        checks++;
        if ({bus.busy, bus.wb_en} !== 2'b00) begin
            failures++; $display("FAIL reset_ctrl got busy,wb_en=%b expected 00", {bus.busy, bus.wb_en});
        end
        checks++;
        if ({div_a, div_b, bus.wb_data, bus.wb_reg} !== '0) begin
            failures++; $display("FAIL reset_data got a=%h b=%h d=%h r=%h expected all 0", div_a, div_b, bus.wb_data, bus.wb_reg);
        end
        checks++;
        if ({sticky_dz, sticky_ov, sticky_uf} !== 3'b000) begin
            failures++; $display("FAIL reset_sticky got %b expected 000", {sticky_dz, sticky_ov, sticky_uf});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int n;
        int busy_cycles;
        bus.op_a = 32'h40C0_0000; bus.op_b = 32'h4000_0000; bus.dest_reg = 5'd3; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.op_a = 32'hDEAD_BEEF; bus.op_b = 32'h1234_5678;
        n = 1; busy_cycles = 0;
        while (!bus.wb_en && n <= 4 * LATENCY + 8) begin
            if (bus.busy) busy_cycles++;
            tick();
            n++;
        end
        if (bus.busy) busy_cycles++;
        checks++;
        if (n != LATENCY + 1) begin
            failures++; $display("FAIL basic_latency got cycle %0d expected %0d", n, LATENCY + 1);
        end
        checks++;
        if ({bus.wb_data, bus.wb_reg} !== {32'h4040_0000, 5'd3}) begin
            failures++; $display("FAIL basic_wb got data=%h reg=%0d expected 40400000 reg 3", bus.wb_data, bus.wb_reg);
        end
        checks++;
        if ({div_a, div_b} !== {32'h40C0_0000, 32'h4000_0000}) begin
            failures++; $display("FAIL basic_hold got a=%h b=%h expected 40c00000 40000000", div_a, div_b);
        end
        tick();
        if (bus.busy) busy_cycles++;
        checks++;
        if (busy_cycles != LATENCY + 1 || bus.wb_en !== 1'b0) begin
            failures++; $display("FAIL basic_busy got busy_cycles=%0d wb_en=%b expected %0d and 0", busy_cycles, bus.wb_en, LATENCY + 1);
        end
        checks++;
        if ({sticky_dz, sticky_ov, sticky_uf} !== 3'b000) begin
            failures++; $display("FAIL basic_sticky got %b expected 000", {sticky_dz, sticky_ov, sticky_uf});
        end
    endtask

    task automatic test_div_zero();
        int n;
        bus.op_a = 32'h3F80_0000; bus.op_b = 32'h0000_0000; bus.dest_reg = 5'd7; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (!bus.wb_en && n < 4 * LATENCY + 8) begin tick(); n++; end
        checks++;
        if (bus.wb_en !== 1'b1 || bus.wb_data !== 32'h7F80_0000) begin
            failures++; $display("FAIL dz_wb got wb_en=%b data=%h expected 1 7f800000", bus.wb_en, bus.wb_data);
        end
        tick();
        exp_sticky = exp_sticky | 3'b100;
        checks++;
        if ({sticky_dz, sticky_ov, sticky_uf} !== exp_sticky) begin
            failures++; $display("FAIL dz_sticky got %b expected %b", {sticky_dz, sticky_ov, sticky_uf}, exp_sticky);
        end
        run_op(32'h40C0_0000, 32'h4000_0000, 5'd4);
        checks++;
        if (sticky_dz !== 1'b1) begin
            failures++; $display("FAIL dz_persist got %b expected 1", sticky_dz);
        end
        flag_clear = 1'b1;
        tick();
        flag_clear = 1'b0;
        exp_sticky = 3'b000;
        checks++;
        if ({sticky_dz, sticky_ov, sticky_uf} !== exp_sticky) begin
            failures++; $display("FAIL dz_clear got %b expected 000", {sticky_dz, sticky_ov, sticky_uf});
        end
    endtask

    task automatic test_flush();
        int wb_seen;
        bus.op_a = 32'h3F80_0000; bus.op_b = 32'h0000_0000; bus.dest_reg = 5'd9; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL flush_busy got %b expected 0", bus.busy);
        end
        wb_seen = 0;
        for (int i = 0; i < LATENCY + 2; i++) begin
            if (bus.wb_en) wb_seen++;
            tick();
        end
        checks++;
        if (wb_seen != 0 || {sticky_dz, sticky_ov, sticky_uf} !== exp_sticky) begin
            failures++; $display("FAIL flush_nowb got wb_pulses=%0d sticky=%b expected 0 and %b", wb_seen, {sticky_dz, sticky_ov, sticky_uf}, exp_sticky);
        end
        // start together with flush in IDLE must be dropped
        bus.op_a = 32'h3F80_0000; bus.op_b = 32'h0000_0000; bus.start = 1'b1; bus.flush = 1'b1;
        tick();
        bus.start = 1'b0; bus.flush = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL flush_start_idle got busy=%b expected 0", bus.busy);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0]           a_log [NCYC];
        logic [31:0]           b_log [NCYC];
        logic [REG_ADDR_W-1:0] d_log [NCYC];
        logic [34:0]           r;
        int                    acc;
        int                    nwb;
        nwb = 0;
        for (int c = 0; c < NCYC; c++) begin
            a_log[c] = $urandom;
            b_log[c] = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : 32'($urandom);
            d_log[c] = REG_ADDR_W'($urandom);
            bus.op_a = a_log[c]; bus.op_b = b_log[c]; bus.dest_reg = d_log[c]; bus.start = 1'b1;
            tick();
            if (bus.wb_en) begin
                nwb++;
                acc = c - int'(LATENCY);
                checks++;
                if (acc < 0 || (acc % (LATENCY + 2)) != 0) begin
                    failures++; $display("FAIL b2b_spacing got wb after edge %0d expected accepts every %0d cycles", c, LATENCY + 2);
                end else begin
                    r = div_model(a_log[acc], b_log[acc]);
                    exp_sticky = exp_sticky | r[2:0];
                    checks++;
                    if ({bus.wb_data, bus.wb_reg} !== {r[34:3], d_log[acc]}) begin
                        failures++; $display("FAIL b2b_data got %h/%0d expected %h/%0d", bus.wb_data, bus.wb_reg, r[34:3], d_log[acc]);
                    end
                end
            end
        end
        bus.start = 1'b0;
        tick();
        checks++;
        if (nwb != (NCYC + 1) / (LATENCY + 2)) begin
            failures++; $display("FAIL b2b_count got %0d write-backs expected %0d", nwb, (NCYC + 1) / (LATENCY + 2));
        end
        checks++;
        if ({sticky_dz, sticky_ov, sticky_uf} !== exp_sticky) begin
            failures++; $display("FAIL b2b_sticky got %b expected %b", {sticky_dz, sticky_ov, sticky_uf}, exp_sticky);
        end
    endtask

    task automatic test_clear_in_wb();
        int n;
        flag_clear = 1'b1; tick(); flag_clear = 1'b0;
        exp_sticky = 3'b000;
        run_op(32'h3F80_0018, 32'h4000_0018, 5'd2);
        checks++;
        if ({sticky_dz, sticky_ov, sticky_uf} !== 3'b011) begin
            failures++; $display("FAIL clrwb_pre got %b expected 011", {sticky_dz, sticky_ov, sticky_uf});
        end
        bus.op_a = 32'h3F80_0000; bus.op_b = 32'h0000_0000; bus.dest_reg = 5'd1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (!bus.wb_en && n < 4 * LATENCY + 8) begin tick(); n++; end
        checks++;
        if (bus.wb_en !== 1'b1) begin
            failures++; $display("FAIL clrwb_timeout got no wb_en within %0d cycles expected a pulse", n);
        end
        flag_clear = 1'b1;
        tick();
        flag_clear = 1'b0;
        exp_sticky = 3'b100;
        checks++;
        if ({sticky_dz, sticky_ov, sticky_uf} !== exp_sticky) begin
            failures++; $display("FAIL clrwb_sticky got %b expected %b", {sticky_dz, sticky_ov, sticky_uf}, exp_sticky);
        end
    endtask

    task automatic test_random();
        logic [31:0]           a, b, got_data;
        logic [REG_ADDR_W-1:0] d, got_reg;
        logic [34:0]           r;
        int                    fc, wb_cyc, extra, exp_cyc;
        bit                    clr, flushed;
        for (int op = 0; op < 12; op++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'h0000_0000 : 32'($urandom);
            d = REG_ADDR_W'($urandom);
            fc = $urandom_range(0, LATENCY + 3);
            clr = ($urandom_range(0, 3) == 0);
            flushed = (fc >= 1) && (fc <= int'(LATENCY));
            r = div_model(a, b);
            bus.op_a = a; bus.op_b = b; bus.dest_reg = d; bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            wb_cyc = 0; extra = 0; got_data = '0; got_reg = '0;
            for (int cyc = 1; cyc <= int'(LATENCY) + 3; cyc++) begin
                if (bus.wb_en) begin
                    if (wb_cyc == 0) begin
                        wb_cyc = cyc; got_data = bus.wb_data; got_reg = bus.wb_reg;
                    end else begin
                        extra++;
                    end
                end
                bus.flush = (cyc == fc);
                flag_clear = clr && (cyc == int'(LATENCY) + 1);
                tick();
            end
            bus.flush = 1'b0; flag_clear = 1'b0;
            if (flushed) exp_sticky = clr ? 3'b000 : exp_sticky;
            else         exp_sticky = clr ? r[2:0] : (exp_sticky | r[2:0]);
            exp_cyc = flushed ? 0 : int'(LATENCY) + 1;
            checks++;
            if (wb_cyc != exp_cyc || extra != 0) begin
                failures++; $display("FAIL rand_wb_timing op=%0d got cycle %0d extra %0d expected cycle %0d", op, wb_cyc, extra, exp_cyc);
            end
            if (!flushed) begin
                checks++;
                if ({got_data, got_reg} !== {r[34:3], d}) begin
                    failures++; $display("FAIL rand_wb_data op=%0d got %h/%0d expected %h/%0d", op, got_data, got_reg, r[34:3], d);
                end
            end
            checks++;
            if ({sticky_dz, sticky_ov, sticky_uf} !== exp_sticky) begin
                failures++; $display("FAIL rand_sticky op=%0d got %b expected %b", op, {sticky_dz, sticky_ov, sticky_uf}, exp_sticky);
            end
        end
    endtask

`ifdef FP_DIV_SEQ_PERF_EN
    task automatic test_perf();
        perf_clear = 1'b1; tick(); perf_clear = 1'b0;
        checks++;
        if ({div_count, flush_count} !== 64'd0) begin
            failures++; $display("FAIL perf_clear0 got %0d/%0d expected 0/0", div_count, flush_count);
        end
        for (int i = 0; i < 3; i++) run_op($urandom, 32'h4000_0000, REG_ADDR_W'(i));
        bus.op_a = 32'h3F80_0000; bus.op_b = 32'h4000_0000; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.flush = 1'b1; tick(); bus.flush = 1'b0;
        tick();
        checks++;
        if (div_count !== 32'd3 || flush_count !== 32'd1) begin
            failures++; $display("FAIL perf_counts got %0d/%0d expected 3/1", div_count, flush_count);
        end
        perf_clear = 1'b1;
        run_op(32'h40C0_0000, 32'h4000_0000, 5'd5);
        perf_clear = 1'b0;
        checks++;
        if ({div_count, flush_count} !== 64'd0) begin
            failures++; $display("FAIL perf_priority got %0d/%0d expected 0/0", div_count, flush_count);
        end
    endtask
`endif

    task automatic test_reset_mid();
        int wb_seen, busy_seen;
        run_op(32'h3F80_0000, 32'h0000_0000, 5'd6);
        bus.op_a = 32'h40C0_0000; bus.op_b = 32'h4000_0000; bus.dest_reg = 5'd8; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        exp_sticky = 3'b000;
        checks++;
        if ({bus.busy, bus.wb_en, sticky_dz, sticky_ov, sticky_uf} !== 5'b0) begin
            failures++; $display("FAIL rstmid_ctrl got busy=%b wb_en=%b sticky=%b expected all 0", bus.busy, bus.wb_en, {sticky_dz, sticky_ov, sticky_uf});
        end
        checks++;
        if ({div_a, div_b, bus.wb_data, bus.wb_reg} !== '0) begin
            failures++; $display("FAIL rstmid_data got a=%h b=%h d=%h r=%h expected all 0", div_a, div_b, bus.wb_data, bus.wb_reg);
        end
        tick();
        rst_n = 1'b1;
        wb_seen = 0; busy_seen = 0;
        for (int i = 0; i < LATENCY + 3; i++) begin
            tick();
            if (bus.wb_en) wb_seen++;
            if (bus.busy) busy_seen++;
        end
        checks++;
        if (wb_seen != 0 || busy_seen != 0) begin
            failures++; $display("FAIL rstmid_after got wb_pulses=%0d busy_cycles=%0d expected 0 and 0", wb_seen, busy_seen);
        end
    endtask

    initial begin
`ifdef FP_DIV_SEQ_PERF_EN
        perf_clear = 1'b0;
`endif
        test_reset();
        test_basic();
        test_div_zero();
        test_flush();
        test_back_to_back();
        test_clear_in_wb();
        test_random();
`ifdef FP_DIV_SEQ_PERF_EN
        test_perf();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no completion expected finish before 500us");
        $fatal(1);
    end
endmodule
